// File: rtl/display_pkg.sv
// Shared constants and the digit-code helper for the multiplexed seven-segment scanner.
package display_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned BCD_W      = 4;
    localparam int unsigned POS_W      = 2;
    localparam logic [BCD_W-1:0] BLANK_CODE = 4'hF;

    // Leading zeros blank only when every more-significant nibble is also zero.
    function automatic logic [BCD_W-1:0] digit_code(
        input logic [NUM_DIGITS*BCD_W-1:0] val,
        input logic [POS_W-1:0]            pos,
        input logic                        blank_lz
    );
        logic [BCD_W-1:0] nib;
        logic             upper_zero;
        nib        = val[pos*BCD_W +: BCD_W];
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(pos) && val[i*BCD_W +: BCD_W] != '0) begin
                upper_zero = 1'b0;
            end
        end
        if (nib > 4'd9) begin
            return BLANK_CODE;
        end
        if (blank_lz && pos != '0 && upper_zero) begin
            return BLANK_CODE;
        end
        return nib;
    endfunction

endpackage

// File: rtl/refresh_tick.sv
// Free-running divider: asserts tick for one cycle every DIV clocks.
module refresh_tick #(
    parameter int unsigned DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_count;

    assign tick = (r_count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/display_scanner.sv
// Four-digit multiplexed display scanner with frame-aligned updates and leading-zero blanking.
module display_scanner
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic [NUM_DIGITS*BCD_W-1:0] bcd_in,
    output logic [BCD_W-1:0]            digit,
    output logic [NUM_DIGITS-1:0]       an,
    output logic                        frame_done
);

    logic                        w_tick;
    logic                        w_boundary;
    logic [POS_W-1:0]            r_pos;
    logic [NUM_DIGITS*BCD_W-1:0] r_active;
    logic [NUM_DIGITS*BCD_W-1:0] r_pending;
    logic                        r_pending_valid;
    logic [BCD_W-1:0]            r_digit;
    logic [NUM_DIGITS-1:0]       r_an;

    refresh_tick #(
        .DIV (REFRESH_DIV)
    ) u_refresh_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    assign w_boundary = w_tick && (r_pos == POS_W'(NUM_DIGITS - 1));
    assign frame_done = w_boundary;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos <= '0;
        end else if (w_tick) begin
            r_pos <= r_pos + POS_W'(1);
        end
    end

    // A load landing on the boundary bypasses pending so it is not lost for a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active        <= '0;
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
        end else if (w_boundary) begin
            if (load) begin
                r_active <= bcd_in;
            end else if (r_pending_valid) begin
                r_active <= r_pending;
            end
            r_pending_valid <= 1'b0;
        end else if (load) begin
            r_pending       <= bcd_in;
            r_pending_valid <= 1'b1;
        end
    end

    // Anodes are forced off for the cycle right after each position advance (ghosting guard).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= BLANK_CODE;
            r_an    <= '1;
        end else begin
            r_digit <= digit_code(r_active, r_pos, BLANK_LZ);
            r_an    <= w_tick ? '1 : ~(NUM_DIGITS'(1) << r_pos);
        end
    end

    assign digit = r_digit;
    assign an    = r_an;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: directed and random loads on two instances (blanking on/off).
module tb_display_scanner;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        load   = 1'b0;
    logic [15:0] bcd_in = '0;

    logic [3:0] digit_lz, an_lz, digit_nz, an_nz;
    logic       fd_lz, fd_nz;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: edges since reset release, and the frame-level display state.
    int          n_edge   = 0;
    logic [15:0] m_active = '0;
    logic [15:0] m_pend   = '0;
    bit          m_pvalid = 1'b0;

    always #5 clk = ~clk;

    display_scanner #(
        .REFRESH_DIV (DIV),
        .BLANK_LZ    (1'b1)
    ) u_dut_lz (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .bcd_in     (bcd_in),
        .digit      (digit_lz),
        .an         (an_lz),
        .frame_done (fd_lz)
    );

    display_scanner #(
        .REFRESH_DIV (DIV),
        .BLANK_LZ    (1'b0)
    ) u_dut_nz (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .bcd_in     (bcd_in),
        .digit      (digit_nz),
        .an         (an_nz),
        .frame_done (fd_nz)
    );

    // Blank when invalid, or (with lz) when the position lies above the most significant nonzero.
    function automatic logic [3:0] ref_digit(input logic [15:0] v, input int p, input bit lz);
        int         msd;
        logic [3:0] nib;
        msd = 0;
        for (int i = 0; i < 4; i++) begin
            if (((v >> (4 * i)) & 16'h000F) != 16'h0000) msd = i;
        end
        nib = 4'((v >> (4 * p)) & 16'h000F);
        if (nib > 4'd9) return 4'hF;
        if (lz && p > msd) return 4'hF;
        return nib;
    endfunction

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, n_edge);
    endtask

    task automatic step(input bit ld, input logic [15:0] d);
        int          p;
        logic [3:0]  e_an;
        logic [15:0] shown;
        load   = ld;
        bcd_in = d;
        p      = (n_edge / DIV) % 4;
        e_an   = (n_edge % DIV == DIV - 1) ? 4'hF : ~(4'(1) << p);
        shown  = m_active;
        if (n_edge % FRAME == FRAME - 1) begin
            m_active = ld ? d : (m_pvalid ? m_pend : m_active);
            m_pvalid = 1'b0;
        end else if (ld) begin
            m_pend   = d;
            m_pvalid = 1'b1;
        end
        n_edge++;
        @(posedge clk);
        #1;
        load = 1'b0;
        check("an_lz", an_lz, e_an);
        check("an_nz", an_nz, e_an);
        check("digit_lz", digit_lz, ref_digit(shown, p, 1'b1));
        check("digit_nz", digit_nz, ref_digit(shown, p, 1'b0));
        check("frame_done", {3'b000, fd_lz},
              {3'b000, (n_edge % FRAME == FRAME - 1) ? 1'b1 : 1'b0});
        check("frame_done_nz", {3'b000, fd_nz},
              {3'b000, (n_edge % FRAME == FRAME - 1) ? 1'b1 : 1'b0});
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) step(1'b0, 16'h0000);
    endtask

    task automatic idle_until(input int phase);
        for (int k = 0; k < FRAME && (n_edge % FRAME) != phase; k++) step(1'b0, 16'h0000);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"}, an_lz, 4'hF);
        check({tag, "_digit"}, digit_lz, 4'hF);
        check({tag, "_digit_nz"}, digit_nz, 4'hF);
        check({tag, "_fd"}, {3'b000, fd_lz}, 4'h0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n    = 1'b1;
        n_edge   = 0;
        m_active = '0;
        m_pend   = '0;
        m_pvalid = 1'b0;
    endtask

    initial begin
        logic [15:0] rnd;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        release_reset();

        idle(2 * FRAME);                          // blank scan of zero

        idle_until(5);
        step(1'b1, 16'h1234);
        idle(2 * FRAME);

        idle_until(2);
        step(1'b1, 16'h1111);
        step(1'b0, 16'h0000);
        step(1'b1, 16'h2222);
        idle(2 * FRAME);

        idle_until(1);
        step(1'b1, 16'h00A5);
        idle(2 * FRAME);

        idle_until(FRAME - 1);                    // load on the boundary tick
        step(1'b1, 16'h4321);
        idle(FRAME);

        for (int k = 0; k < 320; k++) begin
            rnd = '0;
            for (int j = 0; j < 4; j++) rnd[4*j +: 4] = 4'($urandom_range(0, 11));
            if ($urandom_range(0, 1) == 1) rnd = rnd >> (4 * $urandom_range(0, 3));
            step($urandom_range(0, 5) == 0, rnd);
        end

        idle_until(3);
        step(1'b1, 16'h9999);
        idle(3);
        #2;
        rst_n = 1'b0;                              // asynchronous, away from any edge
        #1;
        check_reset_outputs("async_reset");
        release_reset();
        idle(2 * FRAME + 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clk cycles per digit slot (1 kHz per digit at 50 MHz); legal range 2..2^20.
REQ-002 Parameter BLANK_LZ, default 1, enables leading-zero blanking when 1.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 load  input  1  single-cycle strobe: capture bcd_in.
REQ-006 bcd_in  input  16  four BCD digits, [3:0] least significant position.
REQ-007 digit  output  4  digit code to the seven-segment decoder; 4'hF means blank.
REQ-008 an  output  4  digit enables, active-low, one-hot when active.
REQ-009 frame_done  output  1  one-cycle pulse when position 3 slot ends.

Function
REQ-010 Tick counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; tick is asserted in the cycle where count == REFRESH_DIV-1.
REQ-011 Position counter pos (0..3) SHALL advance on tick, wrapping 3->0.
REQ-012 A load SHALL capture bcd_in into a pending register and set pending_valid; a later load before apply SHALL overwrite pending, with the last value winning.
REQ-013 Pending SHALL be copied to the active register, and pending_valid cleared, only on tick with pos == 3 (the frame boundary); the display never changes mid-frame.
REQ-014 If load and the frame-boundary tick coincide, the active register SHALL take bcd_in directly in that cycle.
REQ-015 A nibble > 9 in the active register SHALL be output as 4'hF (blank).
REQ-016 With BLANK_LZ=1, positions 3..1 SHALL output 4'hF when their nibble is 0 and all more-significant nibbles are 0; position 0 is never blanked.
REQ-017 digit and an SHALL be registered, one clk after pos/active change.
REQ-018 For exactly one clk after each pos advance, an SHALL be 4'b1111 (dead time); thereafter an[pos] = 0, with the other bits set to 1.
REQ-019 frame_done SHALL pulse for one clk, coincident with the tick at pos == 3.
REQ-020 Inputs SHALL be synchronous to clk; no handshake back-pressure exists, so load is always accepted.

Reset
REQ-021 While rst_n = 0: tick count = 0, pos = 0, active = 16'h0000, pending = 0, pending_valid = 0, digit = 4'hF, an = 4'b1111, frame_done = 0.
REQ-022 Reset assertion mid-frame SHALL discard pending data immediately.
REQ-023 After release, the first tick occurs REFRESH_DIV cycles later.

Structure
REQ-024 Package display_pkg SHALL hold NUM_DIGITS = 4, BLANK_CODE = 4'hF, and the BCD nibble width of 4.
REQ-025 The tick generator SHALL be a sub-module refresh_tick (parameter DIV, ports clk, rst_n, tick).
REQ-026 The digit output connects directly to the seven-segment decoder input; no extra logic is placed between them.

Verification (REFRESH_DIV=4 unless stated)
REQ-027 Reset release, no load -> an cycles 1110,1101,1011,0111 (each preceded by 1111 for one clk); digit = 0 at pos 0 and 4'hF at pos 1-3.
REQ-028 load bcd_in=16'h1234 mid-frame -> the display shows the old value until frame_done; the next frame shows 4,3,2,1 at pos 0..3.
REQ-029 Two loads 16'h1111 then 16'h2222 within one frame -> only 2222 is displayed.
REQ-030 load 16'h00A5 with BLANK_LZ=1 -> pos 0 = 5, pos 1 = F (invalid nibble), pos 2 = F, pos 3 = F; with BLANK_LZ=0 -> 5, F, 0, 0.
REQ-031 load coincident with the frame-boundary tick -> the new value appears at pos 0 in the very next frame.
REQ-032 rst_n pulsed low mid-frame with pending 16'h9999 -> outputs go to reset values asynchronously, and 0 is displayed after release.
